// File: rtl/mips_icache_pkg.sv
// Shared MIPS definitions for the instruction cache slice.
// Holds the address/data widths, cache line geometry and the width of the
// performance counters.
package mips_icache_pkg;

  localparam int MIPS_ADDR_WIDTH = 32;
  localparam int MIPS_DATA_WIDTH = 32;
  localparam int WORDS_PER_LINE  = 4;
  localparam int LINE_W          = WORDS_PER_LINE * MIPS_DATA_WIDTH;
  localparam int PERF_CNT_W      = 32;

endpackage

// File: rtl/mips_icache_ctrl.sv
// Refill controller for mips_icache.
// Two-state FSM (IDLE/REFILL) plus the line address latched at the miss.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   proc_read     fetch request
//   lookup_hit    valid & tag match for the current proc_addr (not state-gated)
//   proc_addr     word address of the request
//   mem_ready     refill data valid
//   idle          FSM is in IDLE (lookups allowed)
//   miss_start    IDLE->REFILL transition happens at the next edge
//   fill_en       line write strobe (REFILL & mem_ready)
//   mem_read      refill request to memory
//   mem_addr      latched line address of the miss
import mips_icache_pkg::*;

module mips_icache_ctrl (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       proc_read,
  input  logic                       lookup_hit,
  input  logic [MIPS_ADDR_WIDTH-3:0] proc_addr,
  input  logic                       mem_ready,
  output logic                       idle,
  output logic                       miss_start,
  output logic                       fill_en,
  output logic                       mem_read,
  output logic [MIPS_ADDR_WIDTH-5:0] mem_addr
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  logic [0:0] state;

  assign idle       = (state == IDLE);
  assign miss_start = idle & proc_read & ~lookup_hit;
  // Reset forces IDLE asynchronously, so both strobes drop at once and a
  // pending refill never writes the arrays.
  assign mem_read   = (state == REFILL);
  assign fill_en    = (state == REFILL) & mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (miss_start) state <= REFILL;
        REFILL:  if (mem_ready)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The address only changes on a new miss, so it stays stable through
  // REFILL regardless of what the fetch stage does meanwhile.
  always_ff @(posedge clk) begin
    if (miss_start) mem_addr <= proc_addr[MIPS_ADDR_WIDTH-3:2];
  end

endmodule

// File: rtl/mips_icache.sv
// Direct-mapped, read-only MIPS instruction cache with zero-wait hits.
// NUM_LINES lines of 4 words; a miss refills one whole line from memory.
// Optional feature: define MIPS_ICACHE_PERF_EN to build saturating hit/miss
// counters; otherwise perf_hit_cnt/perf_miss_cnt are tied to 0.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   proc_read/proc_write/proc_addr/proc_wdata   fetch side requests (writes ignored)
//   proc_rdata, proc_stall           fetched word, request-not-served flag
//   mem_read/mem_write/mem_addr/mem_wdata       refill request (write side constant 0)
//   mem_rdata, mem_ready             refill line and its completion strobe
//   perf_hit_cnt, perf_miss_cnt      performance counters
import mips_icache_pkg::*;

module mips_icache #(
  parameter int NUM_LINES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       proc_read,
  input  logic                       proc_write,
  input  logic [MIPS_ADDR_WIDTH-3:0] proc_addr,
  input  logic [MIPS_DATA_WIDTH-1:0] proc_wdata,
  output logic [MIPS_DATA_WIDTH-1:0] proc_rdata,
  output logic                       proc_stall,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [MIPS_ADDR_WIDTH-5:0] mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic [PERF_CNT_W-1:0]      perf_hit_cnt,
  output logic [PERF_CNT_W-1:0]      perf_miss_cnt
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = MIPS_ADDR_WIDTH - 4 - IDX_W;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_LINES-1:0]       valid;
  logic [TAG_W-1:0]           tag_mem  [NUM_LINES];
  logic [MIPS_DATA_WIDTH-1:0] data_mem [NUM_LINES][WORDS_PER_LINE];

  logic [1:0]       offset;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             lookup_hit, hit, idle, miss_start, fill_en;
  logic             unused_write_side;

  assign offset = proc_addr[1:0];
  assign idx    = proc_addr[2 +: IDX_W];
  assign tag    = proc_addr[MIPS_ADDR_WIDTH-3 -: TAG_W];

  assign lookup_hit = valid[idx] & (tag_mem[idx] == tag);
  assign hit        = proc_read & idle & lookup_hit;

  assign proc_rdata = hit ? data_mem[idx][offset] : '0;
  assign proc_stall = proc_read & ~hit;

  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;
  assign unused_write_side = ^{proc_write, proc_wdata};

  mips_icache_ctrl u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .lookup_hit (lookup_hit),
    .proc_addr  (proc_addr),
    .mem_ready  (mem_ready),
    .idle       (idle),
    .miss_start (miss_start),
    .fill_en    (fill_en),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr)
  );

  assign fill_idx = mem_addr[IDX_W-1:0];
  assign fill_tag = mem_addr[MIPS_ADDR_WIDTH-5 -: TAG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx] <= fill_tag;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        data_mem[fill_idx][w] <= mem_rdata[w*MIPS_DATA_WIDTH +: MIPS_DATA_WIDTH];
      end
    end
  end

`ifdef MIPS_ICACHE_PERF_EN
  logic [PERF_CNT_W-1:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)        hit_cnt  <= sat_inc(hit_cnt);
      if (miss_start) miss_cnt <= sat_inc(miss_cnt);
    end
  end

  assign perf_hit_cnt  = hit_cnt;
  assign perf_miss_cnt = miss_cnt;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_icache.sv
// Self-checking bench for mips_icache (NUM_LINES = 8).
// A fetch task pushes the expected instruction word into a scoreboard queue
// and pops it when the cache finally serves the request; stall length,
// mem_read behaviour and address stability are checked inline.
module tb_mips_icache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic [31:0]  perf_hit_cnt, perf_miss_cnt;

  int vec  = 0;
  int errs = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mips_icache #(.NUM_LINES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .proc_read     (proc_read),
    .proc_write    (proc_write),
    .proc_addr     (proc_addr),
    .proc_wdata    (proc_wdata),
    .proc_rdata    (proc_rdata),
    .proc_stall    (proc_stall),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
  );

  // Memory model: word w of line la.
  function automatic logic [127:0] line_of(input logic [27:0] la);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = ({4'h0, la} * 32'h01010101) + 32'hA0 + w;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [29:0] a);
    logic [127:0] l;
    l = line_of(a[29:2]);
    return l[a[1:0]*32 +: 32];
  endfunction

  // Called just after a rising edge. Returns the number of stalled cycles
  // and whether mem_read was ever seen.
  task automatic fetch(input logic [29:0] a, input int mw, input logic wr,
                       output int stalls, output bit saw_mem_read);
    int  waited;
    bit  done;
    logic [31:0] got;
    stalls = 0; waited = 0; done = 0; saw_mem_read = 0;
    proc_read = 1'b1; proc_write = wr; proc_addr = a; proc_wdata = 32'hDEAD_BEEF;
    exp_q.push_back(word_of(a));
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (!proc_stall) begin
        got = exp_q.pop_front();
        vec++;
        if (proc_rdata !== got) begin
          errs++;
          $display("FAIL rdata addr=%h got=%h exp=%h", a, proc_rdata, got);
        end
        done = 1;
      end else begin
        stalls++;
        if (mem_read) begin
          vec++;
          if (mem_addr !== a[29:2]) begin
            errs++;
            $display("FAIL mem_addr addr=%h got=%h exp=%h", a, mem_addr, a[29:2]);
          end
          saw_mem_read = 1;
          if (waited == mw) begin
            mem_ready = 1'b1;
            mem_rdata = line_of(a[29:2]);
          end else begin
            waited++;
          end
        end
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    proc_read = 1'b0; proc_write = 1'b0;
    if (!done) begin
      void'(exp_q.pop_front());
      vec++; errs++;
      $display("FAIL timeout addr=%h got=no_service exp=served", a);
    end
  endtask

  task automatic expect_miss(input logic [29:0] a, input int mw, input string nm);
    int s; bit m;
    fetch(a, mw, 1'b0, s, m);
    vec++;
    if (s !== mw + 2 || !m) begin
      errs++;
      $display("FAIL %s stalls=%0d memrd=%0d exp stalls=%0d memrd=1", nm, s, m, mw + 2);
    end
  endtask

  task automatic expect_hit(input logic [29:0] a, input logic wr, input string nm);
    int s; bit m;
    fetch(a, 0, wr, s, m);
    vec++;
    if (s !== 0 || m) begin
      errs++;
      $display("FAIL %s stalls=%0d memrd=%0d exp stalls=0 memrd=0", nm, s, m);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    rst_n = 1'b0;
    #1;
    vec++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h0 || mem_read !== 1'b0 ||
        mem_write !== 1'b0 || mem_wdata !== 128'h0) begin
      errs++;
      $display("FAIL reset_outputs stall=%b rdata=%h memrd=%b memwr=%b wdata=%h exp all 0",
               proc_stall, proc_rdata, mem_read, mem_write, mem_wdata);
    end
    vec++;
    if (perf_hit_cnt !== 32'h0 || perf_miss_cnt !== 32'h0) begin
      errs++;
      $display("FAIL reset_perf hit=%0d miss=%0d exp 0 0", perf_hit_cnt, perf_miss_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    expect_miss(30'h10, 3, "cold_miss");
  endtask

  task automatic test_hits();
    for (int i = 0; i < 4; i++) expect_hit(30'h10 + i, 1'b0, "hit_seq");
  endtask

  task automatic test_conflict();
    expect_miss(30'h00, 1, "conflict_a");
    expect_miss(30'h20, 2, "conflict_b");
    expect_miss(30'h01, 0, "conflict_a_again");
    expect_hit(30'h02, 1'b0, "conflict_a_hit");
  endtask

  task automatic test_write_ignored();
    proc_write = 1'b1; proc_read = 1'b0; proc_addr = 30'h18;
    @(negedge clk);
    vec++;
    if (proc_stall !== 1'b0) begin
      errs++; $display("FAIL write_only_stall got=%b exp=0", proc_stall);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if (mem_read !== 1'b0) begin
      errs++; $display("FAIL write_only_memrd got=%b exp=0", mem_read);
    end
    @(posedge clk); #1;
    proc_write = 1'b0;
    // read+write together behaves as a read
    begin
      int s; bit m;
      fetch(30'h18, 0, 1'b1, s, m);
      vec++;
      if (s !== 2) begin
        errs++; $display("FAIL read_write_miss stalls=%0d exp=2", s);
      end
    end
    expect_hit(30'h1B, 1'b1, "read_write_hit");
  endtask

  task automatic test_ready_in_idle();
    mem_ready = 1'b1; mem_rdata = {4{32'hBAD0_BAD0}};
    proc_addr = 30'h14;
    @(negedge clk);
    vec++;
    if (mem_read !== 1'b0) begin
      errs++; $display("FAIL idle_ready_memrd got=%b exp=0", mem_read);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    expect_miss(30'h14, 1, "idle_ready_miss");
  endtask

  task automatic test_abort();
    proc_read = 1'b1; proc_addr = 30'h48;
    @(negedge clk);
    @(posedge clk); #1;
    proc_read = 1'b0; proc_addr = 30'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (mem_read !== 1'b1 || proc_stall !== 1'b0 || mem_addr !== 28'h12) begin
        errs++;
        $display("FAIL abort_hold memrd=%b stall=%b maddr=%h exp 1 0 12", mem_read, proc_stall, mem_addr);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = line_of(28'h12);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    vec++;
    if (mem_read !== 1'b0) begin
      errs++; $display("FAIL abort_done memrd=%b exp=0", mem_read);
    end
    @(posedge clk); #1;
    expect_hit(30'h49, 1'b0, "abort_line_hit");
  endtask

  task automatic test_reset_mid_refill();
    proc_read = 1'b1; proc_addr = 30'h80;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    vec++;
    if (mem_read !== 1'b1) begin
      errs++; $display("FAIL rst_mid_pre memrd=%b exp=1", mem_read);
    end
    mem_rdata = line_of(28'h20);
    rst_n = 1'b0;
    #1;
    vec++;
    if (mem_read !== 1'b0) begin
      errs++; $display("FAIL rst_mid_memrd got=%b exp=0", mem_read);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; proc_read = 1'b0;
    rst_n = 1'b1;
    expect_miss(30'h80, 1, "rst_mid_line_miss");
    expect_miss(30'h10, 2, "rst_mid_old_miss");
  endtask

  task automatic test_perf();
    do_reset();
    // Each miss ends in one served hit cycle: 2 miss fetches + 4 hit fetches = 6 hit cycles.
    expect_miss(30'h200, 1, "perf_miss0");
    expect_hit(30'h201, 1'b0, "perf_hit0");
    expect_hit(30'h202, 1'b0, "perf_hit1");
    expect_miss(30'h304, 0, "perf_miss1");
    expect_hit(30'h305, 1'b0, "perf_hit2");
    expect_hit(30'h306, 1'b0, "perf_hit3");
    @(negedge clk);
    vec++;
`ifdef MIPS_ICACHE_PERF_EN
    if (perf_miss_cnt !== 32'd2 || perf_hit_cnt !== 32'd6) begin
      errs++;
      $display("FAIL perf_counts miss=%0d hit=%0d exp miss=2 hit=6", perf_miss_cnt, perf_hit_cnt);
    end
`else
    if (perf_miss_cnt !== 32'd0 || perf_hit_cnt !== 32'd0) begin
      errs++;
      $display("FAIL perf_tied miss=%0d hit=%0d exp 0 0", perf_miss_cnt, perf_hit_cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_write_ignored();
    test_ready_in_idle();
    test_abort();
    test_reset_mid_refill();
    test_perf();
    vec++;
    if (exp_q.size() != 0) begin
      errs++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
